// File: rtl/read_bank_mux.sv
// read_bank_mux
//   Read-side companion to the multi-bank write accounter. A read request
//   is broadcast to every bank. The accounter selector captured at
//   request time travels through a tag pipeline that matches the RAM
//   latency, then picks the returning bank word. The word and its
//   write-collision flag leave through a valid/ready output stage.
//
//   Configuration macro: READ_BACKPRESSURE_EN
//     defined   - credit-managed output FIFO; rdready is honoured.
//     undefined - single output register; rdvalid is a one-cycle pulse,
//                 rdgrant is tied high and rdready is ignored.
//
// Ports
//   aclk, aresetn            clock, asynchronous active-low reset
//   rden, rdaddr, rdgrant    read request / address / acceptance
//   bank_select              accounter selector for rdaddr
//   ram_rden, ram_rdaddr     read enable and address broadcast to all banks
//   ram_rddata               concatenated bank data, bank i at [i*DATA_WIDTH +: DATA_WIDTH]
//   rdvalid, rdready         output handshake
//   rddata, rdcollision      selected word and its collision flag
module read_bank_mux #(
  parameter int ADDR_WIDTH      = 8,
  parameter int DATA_WIDTH      = 32,
  parameter int NB_WRAGENT      = 2,
  parameter int WRITE_COLLISION = 1,
  parameter int SELECT_WIDTH    = (NB_WRAGENT == 1 ? 1 : $clog2(NB_WRAGENT)) + WRITE_COLLISION,
  parameter int RAM_LATENCY     = 1,
  parameter int FIFO_DEPTH      = RAM_LATENCY + 2
) (
  input  logic                           aclk,
  input  logic                           aresetn,
  input  logic                           rden,
  input  logic [ADDR_WIDTH-1:0]          rdaddr,
  output logic                           rdgrant,
  input  logic [SELECT_WIDTH-1:0]        bank_select,
  output logic                           ram_rden,
  output logic [ADDR_WIDTH-1:0]          ram_rdaddr,
  input  logic [NB_WRAGENT*DATA_WIDTH-1:0] ram_rddata,
  output logic                           rdvalid,
  input  logic                           rdready,
  output logic [DATA_WIDTH-1:0]          rddata,
  output logic                           rdcollision
);

  localparam int IDX_W = SELECT_WIDTH - WRITE_COLLISION;

  logic                    acc;
  logic [RAM_LATENCY-1:0]  tag_valid_q, tag_valid_d;
  logic [SELECT_WIDTH-1:0] tag_sel_q [RAM_LATENCY];
  logic [SELECT_WIDTH-1:0] tag_sel_d [RAM_LATENCY];
  logic                    exit_valid;
  logic [SELECT_WIDTH-1:0] exit_sel;
  logic [IDX_W-1:0]        exit_idx;
  logic                    exit_coll;
  logic [DATA_WIDTH-1:0]   mux_data;
  logic                    mux_coll;

  assign acc        = rden & rdgrant;
  assign ram_rden   = acc;
  assign ram_rdaddr = rdaddr;

  // Tag pipeline: one stage per cycle of RAM latency, so the selector
  // emerges in the same cycle as the bank data it describes.
  always_comb begin
    tag_valid_d[0] = acc;
    tag_sel_d[0]   = bank_select;
    for (int i = 1; i < RAM_LATENCY; i++) begin
      tag_valid_d[i] = tag_valid_q[i-1];
      tag_sel_d[i]   = tag_sel_q[i-1];
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tag_valid_q <= '0;
      for (int i = 0; i < RAM_LATENCY; i++) tag_sel_q[i] <= '0;
    end else begin
      tag_valid_q <= tag_valid_d;
      for (int i = 0; i < RAM_LATENCY; i++) tag_sel_q[i] <= tag_sel_d[i];
    end
  end

  assign exit_valid = tag_valid_q[RAM_LATENCY-1];
  assign exit_sel   = tag_sel_q[RAM_LATENCY-1];
  assign exit_idx   = exit_sel[IDX_W-1:0];

  generate
    if (WRITE_COLLISION != 0) begin : g_coll
      assign exit_coll = exit_sel[SELECT_WIDTH-1];
    end else begin : g_no_coll
      assign exit_coll = 1'b0;
    end
  endgenerate

  // An index beyond the populated banks matches no case below and so
  // returns a zero word with the collision flag cleared.
  always_comb begin
    mux_data = '0;
    mux_coll = 1'b0;
    for (int b = 0; b < NB_WRAGENT; b++) begin
      if (exit_idx == IDX_W'(b)) begin
        mux_data = ram_rddata[b*DATA_WIDTH +: DATA_WIDTH];
        mux_coll = exit_coll;
      end
    end
  end

`ifdef READ_BACKPRESSURE_EN
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

  logic [CNT_W-1:0]      fifo_count_q, fifo_count_d, in_flight;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] fifo_data_q [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] fifo_data_d [FIFO_DEPTH];
  logic [FIFO_DEPTH-1:0] fifo_coll_q, fifo_coll_d;
  logic                  push, pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Every accepted read owns a FIFO slot from acceptance until it is
  // popped, so counting pipeline tags plus stored words can never let
  // the FIFO overflow.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RAM_LATENCY; i++) in_flight = in_flight + CNT_W'(tag_valid_q[i]);
  end

  assign rdgrant     = ({1'b0, in_flight} + {1'b0, fifo_count_q}) < (CNT_W+1)'(FIFO_DEPTH);
  assign rdvalid     = (fifo_count_q != '0);
  assign rddata      = rdvalid ? fifo_data_q[rd_ptr_q] : '0;
  assign rdcollision = rdvalid & fifo_coll_q[rd_ptr_q];
  assign push        = exit_valid;
  assign pop         = rdvalid & rdready;

  always_comb begin
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    fifo_count_d = fifo_count_q;
    fifo_data_d  = fifo_data_q;
    fifo_coll_d  = fifo_coll_q;
    if (push) begin
      fifo_data_d[wr_ptr_q] = mux_data;
      fifo_coll_d[wr_ptr_q] = mux_coll;
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end
    if (pop) rd_ptr_d = ptr_inc(rd_ptr_q);
    case ({push, pop})
      2'b10:   fifo_count_d = fifo_count_q + 1'b1;
      2'b01:   fifo_count_d = fifo_count_q - 1'b1;
      default: fifo_count_d = fifo_count_q;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_count_q <= '0;
      fifo_coll_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_q[i] <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_count_q <= fifo_count_d;
      fifo_coll_q  <= fifo_coll_d;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_data_q[i] <= fifo_data_d[i];
    end
  end
`else
  logic                  out_valid_q, out_valid_d;
  logic [DATA_WIDTH-1:0] out_data_q, out_data_d;
  logic                  out_coll_q, out_coll_d;
  logic                  unused_rdready;

  assign unused_rdready = rdready;
  assign rdgrant        = 1'b1;
  assign rdvalid        = out_valid_q;
  assign rddata         = out_data_q;
  assign rdcollision    = out_coll_q;

  // The word is held after its valid pulse until the next read lands.
  always_comb begin
    out_valid_d = exit_valid;
    out_data_d  = exit_valid ? mux_data : out_data_q;
    out_coll_d  = exit_valid ? mux_coll : out_coll_q;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_coll_q  <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_coll_q  <= out_coll_d;
    end
  end
`endif

endmodule

// File: tb/tb_read_bank_mux.sv
module tb_read_bank_mux;

  localparam int AW    = 8;
  localparam int DW    = 32;
  localparam int NB    = 3;
  localparam int SW    = 3;
  localparam int LAT   = 1;
  localparam int DEPTH = LAT + 2;

  logic          aclk;
  logic          aresetn;
  logic          rden;
  logic [AW-1:0] rdaddr;
  logic          rdgrant;
  logic [SW-1:0] bank_select;
  logic          ram_rden;
  logic [AW-1:0] ram_rdaddr;
  logic [NB*DW-1:0] ram_rddata;
  logic          rdvalid;
  logic          rdready;
  logic [DW-1:0] rddata;
  logic          rdcollision;

  read_bank_mux #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NB_WRAGENT(NB),
    .WRITE_COLLISION(1), .RAM_LATENCY(LAT)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .rden(rden), .rdaddr(rdaddr), .rdgrant(rdgrant),
    .bank_select(bank_select),
    .ram_rden(ram_rden), .ram_rdaddr(ram_rdaddr), .ram_rddata(ram_rddata),
    .rdvalid(rdvalid), .rdready(rdready),
    .rddata(rddata), .rdcollision(rdcollision)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  // Bank contents and a latency-LAT RAM read port.
  logic [DW-1:0]    mem [NB][256];
  logic [NB*DW-1:0] ram_pipe [LAT];

  initial for (int s = 0; s < LAT; s++) ram_pipe[s] = '0;

  always @(posedge aclk) begin
    for (int s = LAT - 1; s > 0; s--) ram_pipe[s] <= ram_pipe[s-1];
    if (ram_rden)
      for (int b = 0; b < NB; b++) ram_pipe[0][b*DW +: DW] <= mem[b][ram_rdaddr];
  end
  assign ram_rddata = ram_pipe[LAT-1];

  typedef struct {
    logic [DW-1:0] data;
    logic          coll;
    int            due;
  } item_t;

  item_t         model_q[$];
  int            cyc;
  int            outstanding;
  logic [DW-1:0] last_data;
  logic          last_coll;
  int            checks;
  int            failures;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (t=%0t)", name, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic [AW-1:0] addr,
                               input logic [SW-1:0] sel, input logic rdy);
    @(posedge aclk);
    #1;
    rden        = en;
    rdaddr      = addr;
    bank_select = sel;
    rdready     = rdy;
  endtask

  // What a read must return: selector MSB is the collision flag, low bits
  // pick the bank, and an unpopulated bank gives zero with no collision.
  function automatic item_t expectItem(input logic [AW-1:0] addr, input logic [SW-1:0] sel, input int due);
    item_t it;
    int    idx;
    idx    = int'(sel[1:0]);
    it.due = due;
    if (idx >= NB) begin
      it.data = '0;
      it.coll = 1'b0;
    end else begin
      it.data = mem[idx][addr];
      it.coll = sel[2];
    end
    return it;
  endfunction

  // Reference model and per-cycle comparison.
  always @(negedge aclk) begin
    logic          exp_grant, exp_valid, exp_coll;
    logic [DW-1:0] exp_data;
    if (!aresetn) begin
      model_q.delete();
      cyc         = 0;
      outstanding = 0;
      last_data   = '0;
      last_coll   = 1'b0;
      checkOutput("rst_rdgrant", 64'(rdgrant), 64'd1);
      checkOutput("rst_rdvalid", 64'(rdvalid), 64'd0);
      checkOutput("rst_rddata", 64'(rddata), 64'd0);
      checkOutput("rst_rdcollision", 64'(rdcollision), 64'd0);
      checkOutput("rst_ram_rden", 64'(ram_rden), 64'd0);
    end else begin
`ifdef READ_BACKPRESSURE_EN
      exp_grant = model_q.size() < DEPTH;
      exp_valid = (model_q.size() > 0) && (model_q[0].due <= cyc);
      exp_data  = exp_valid ? model_q[0].data : '0;
      exp_coll  = exp_valid ? model_q[0].coll : 1'b0;
`else
      exp_grant = 1'b1;
      exp_valid = (model_q.size() > 0) && (model_q[0].due == cyc);
      if (exp_valid) begin
        last_data = model_q[0].data;
        last_coll = model_q[0].coll;
        void'(model_q.pop_front());
      end
      exp_data = last_data;
      exp_coll = last_coll;
`endif
      checkOutput("rdgrant", 64'(rdgrant), 64'(exp_grant));
      checkOutput("rdvalid", 64'(rdvalid), 64'(exp_valid));
`ifdef READ_BACKPRESSURE_EN
      if (exp_valid) begin
`else
      begin
`endif
        checkOutput("rddata", 64'(rddata), 64'(exp_data));
        checkOutput("rdcollision", 64'(rdcollision), 64'(exp_coll));
      end
      checkOutput("ram_rden", 64'(ram_rden), 64'(rden & exp_grant));
      if (rden && exp_grant) begin
        checkOutput("ram_rdaddr", 64'(ram_rdaddr), 64'(rdaddr));
        model_q.push_back(expectItem(rdaddr, bank_select, cyc + LAT + 1));
      end
`ifdef READ_BACKPRESSURE_EN
      if (exp_valid && rdready) void'(model_q.pop_front());
      if (rden && rdgrant) outstanding++;
      if (rdvalid && rdready) outstanding--;
      checkOutput("no_overflow", 64'(outstanding <= DEPTH), 64'd1);
`endif
      cyc++;
    end
  end

  initial begin
    int accepts, drained, vcount, run, maxrun, first;
    checks   = 0;
    failures = 0;
    for (int b = 0; b < NB; b++)
      for (int a = 0; a < 256; a++) mem[b][a] = $urandom;
    mem[1][8'h10] = 32'hDEADBEEF;
    mem[0][8'h20] = 32'h12345678;

    rden = 1'b0; rdaddr = '0; bank_select = '0; rdready = 1'b1;
    aresetn = 1'b1;
    #2 aresetn = 1'b0;
    repeat (3) @(posedge aclk);
    #1 aresetn = 1'b1;

    // Single read from bank 1.
    applyStimulus(1'b1, 8'h10, 3'b001, 1'b1);
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b1);
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b1);
    @(negedge aclk); #2;
    checkOutput("single_valid", 64'(rdvalid), 64'd1);
    checkOutput("single_data", 64'(rddata), 64'h00000000DEADBEEF);
    checkOutput("single_coll", 64'(rdcollision), 64'd0);

    // Collision flag on bank 0.
    applyStimulus(1'b1, 8'h20, 3'b100, 1'b1);
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b1);
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b1);
    @(negedge aclk); #2;
    checkOutput("coll_valid", 64'(rdvalid), 64'd1);
    checkOutput("coll_data", 64'(rddata), 64'h0000000012345678);
    checkOutput("coll_flag", 64'(rdcollision), 64'd1);

    // Out-of-range bank index, with and without collision MSB.
    applyStimulus(1'b1, 8'h20, 3'b011, 1'b1);
    applyStimulus(1'b1, 8'h20, 3'b111, 1'b1);
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b1);
    @(negedge aclk); #2;
    checkOutput("oor_data", 64'(rddata), 64'd0);
    checkOutput("oor_coll", 64'(rdcollision), 64'd0);
    applyStimulus(1'b0, 8'h00, 3'b000, 1'b1);
    @(negedge aclk); #2;
    checkOutput("oor_msb_data", 64'(rddata), 64'd0);
    checkOutput("oor_msb_coll", 64'(rdcollision), 64'd0);
    repeat (3) applyStimulus(1'b0, 8'h00, 3'b000, 1'b1);

    // Backpressure: hold rden for 10 cycles with the consumer stalled.
    accepts = 0;
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, AW'(i), SW'(i % 2), 1'b0);
      @(negedge aclk); #2;
      if (rdgrant) accepts++;
    end
    drained = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 8'h00, 3'b000, 1'b1);
      @(negedge aclk); #2;
      if (rdvalid) drained++;
    end
`ifdef READ_BACKPRESSURE_EN
    checkOutput("bp_accepts", 64'(accepts), 64'd3);
    checkOutput("bp_drained", 64'(drained), 64'd3);
`else
    checkOutput("bp_accepts", 64'(accepts), 64'd10);
    checkOutput("bp_drained", 64'(drained), 64'd2);
`endif

    // Streaming: 16 back-to-back reads, alternating banks.
    vcount = 0; run = 0; maxrun = 0; first = -1;
    for (int i = 0; i < 20; i++) begin
      if (i < 16) applyStimulus(1'b1, AW'(i), SW'(i % 2), 1'b1);
      else        applyStimulus(1'b0, 8'h00, 3'b000, 1'b1);
      @(negedge aclk); #2;
      if (rdvalid) begin
        vcount++;
        run++;
        if (first < 0) first = i;
        if (run > maxrun) maxrun = run;
      end else run = 0;
    end
    checkOutput("stream_count", 64'(vcount), 64'd16);
    checkOutput("stream_run", 64'(maxrun), 64'd16);
    checkOutput("stream_first", 64'(first), 64'(LAT + 1));

    // Reset with reads in flight and a word buffered.
    applyStimulus(1'b1, 8'h05, 3'b000, 1'b0);
    applyStimulus(1'b1, 8'h06, 3'b001, 1'b0);
    applyStimulus(1'b1, 8'h07, 3'b000, 1'b0);
    @(posedge aclk); #1;
    rden    = 1'b0;
    aresetn = 1'b0;
    #1;
    checkOutput("midrst_rdvalid", 64'(rdvalid), 64'd0);
    checkOutput("midrst_rdgrant", 64'(rdgrant), 64'd1);
    @(posedge aclk); #1 aresetn = 1'b1;
    vcount = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b0, 8'h00, 3'b000, 1'b1);
      @(negedge aclk); #2;
      if (rdvalid) vcount++;
    end
    checkOutput("midrst_no_stale", 64'(vcount), 64'd0);

    // Randomized traffic checked by the reference model.
    for (int i = 0; i < 1500; i++)
      applyStimulus(($urandom % 4) != 0, AW'($urandom), SW'($urandom_range(0, 7)), ($urandom % 3) != 0);
    repeat (10) applyStimulus(1'b0, 8'h00, 3'b000, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
